// File: rtl/mem_traffic_master_if.sv
// ---------------------------------------------------------------------------
// mem_traffic_master_if
//
// Purpose: valid/ready memory request bus between the traffic master and a
// memory responder. One request is outstanding at a time; the master holds
// valid, addr, wdata and wstrb stable until ready is sampled high.
//
// Signals:
//   mem_valid  master -> slave  request valid
//   mem_instr  master -> slave  instruction fetch flag (always 0 here)
//   mem_addr   master -> slave  byte address
//   mem_wdata  master -> slave  write data
//   mem_wstrb  master -> slave  byte strobes (4'hF write, 4'h0 read)
//   mem_ready  slave  -> master request completion
//   mem_rdata  slave  -> master read data, valid with mem_ready
// ---------------------------------------------------------------------------
interface mem_traffic_master_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_traffic_master.sv
// ---------------------------------------------------------------------------
// mem_traffic_master
//
// Purpose: self-running memory traffic generator. On a start pulse it issues
// NUM_OPS pseudo-random reads/writes into a window of ADDR_WORDS 32-bit words
// at ADDR_BASE, one at a time, measuring worst-case latency and flagging any
// request that waits longer than TIMEOUT cycles for mem_ready.
//
// Optional feature (macro MEM_TRAFFIC_CHECK_EN): a shadow copy of the window
// records every completed write; reads of previously written words are
// compared against it and mismatches counted in err_count. Without the macro
// err_count is tied to 0 and no shadow storage exists.
//
// Ports:
//   clk          in   single clock, rising edge
//   resetn       in   synchronous active-low reset
//   start        in   one-cycle pulse, begins a run from IDLE or DONE
//   busy         out  run in progress
//   done         out  run finished, held until next start or reset
//   timeout_err  out  sticky, a request exceeded TIMEOUT
//   op_count     out  completed transactions in the current run
//   err_count    out  read-data mismatches in the current run (saturating)
//   lat_max      out  worst-case latency in cycles (saturating)
//   mem          if   master side of the memory request bus
// ---------------------------------------------------------------------------
module mem_traffic_master #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_4000,
    parameter int          ADDR_WORDS = 64,
    parameter int          NUM_OPS    = 256,
    parameter int          TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [15:0]             op_count,
    output logic [15:0]             err_count,
    output logic [15:0]             lat_max,
    mem_traffic_master_if.master    mem
);

    localparam int          IDX_W     = $clog2(ADDR_WORDS);
    localparam logic [15:0] NUM_OPS_C = 16'(NUM_OPS);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ISSUE = 5'b00010,
        ST_WAIT  = 5'b00100,
        ST_CHECK = 5'b01000,
        ST_DONE  = 5'b10000
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state, state_nxt;
    logic [15:0]       lfsr;
    logic [15:0]       wait_cnt;
    logic              req_valid;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic [IDX_W-1:0]  lfsr_idx;
    logic              start_run;
    logic              hs;
    logic              tmo;
    logic              last_op;
    logic [15:0]       lat_now;

    assign lfsr_idx  = lfsr[8 +: IDX_W];
    assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign hs        = (state == ST_WAIT) && mem.mem_ready;
    assign tmo       = (state == ST_WAIT) && !mem.mem_ready && (wait_cnt == TIMEOUT_C);
    assign last_op   = (op_count == NUM_OPS_C - 16'd1);
    // wait_cnt is 0 on the first valid cycle, so the inclusive latency is one more.
    assign lat_now   = sat_inc16(wait_cnt);

    assign busy          = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_CHECK);
    assign done          = (state == ST_DONE);
    assign mem.mem_valid = req_valid;
    assign mem.mem_instr = 1'b0;
    assign mem.mem_addr  = req_addr;
    assign mem.mem_wdata = req_wdata;
    assign mem.mem_wstrb = req_wstrb;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_ISSUE;
            ST_ISSUE:         state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mem.mem_ready) begin
                    state_nxt = ST_CHECK;
                end else if (wait_cnt == TIMEOUT_C) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_CHECK:         state_nxt = last_op ? ST_DONE : ST_ISSUE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Request issue, wait accounting and run statistics.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr        <= LFSR_SEED;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_wstrb   <= '0;
            wait_cnt    <= '0;
            op_count    <= '0;
            lat_max     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (start_run) begin
                op_count    <= '0;
                lat_max     <= '0;
                timeout_err <= 1'b0;
            end
            if (state == ST_ISSUE) begin
                req_valid <= 1'b1;
                req_addr  <= ADDR_BASE + (32'(lfsr_idx) << 2);
                req_wdata <= {lfsr, ~lfsr};
                req_wstrb <= lfsr[0] ? 4'hF : 4'h0;
                wait_cnt  <= '0;
            end
            if (hs) begin
                req_valid <= 1'b0;
                if (lat_now > lat_max) lat_max <= lat_now;
            end else if (tmo) begin
                // Abandon the request; the LFSR is not advanced.
                req_valid   <= 1'b0;
                timeout_err <= 1'b1;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (state == ST_CHECK) begin
                op_count <= op_count + 16'd1;
                lfsr     <= lfsr_step(lfsr);
            end
        end
    end

`ifdef MEM_TRAFFIC_CHECK_EN
    logic [31:0]           shadow [ADDR_WORDS];
    logic [ADDR_WORDS-1:0] shadow_vld;
    logic [IDX_W-1:0]      idx_p1;
    logic [31:0]           rdata_p1;

    // Index and response data captured for the CHECK cycle; data only, no reset.
    always_ff @(posedge clk) begin
        if (state == ST_ISSUE) idx_p1 <= lfsr_idx;
        if (hs)                rdata_p1 <= mem.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if ((state == ST_CHECK) && req_wstrb[0]) shadow[idx_p1] <= req_wdata;
    end

    // Valid bits survive across runs; only reset forgets what was written.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow_vld <= '0;
            err_count  <= '0;
        end else begin
            if (start_run) err_count <= '0;
            if (state == ST_CHECK) begin
                if (req_wstrb[0]) begin
                    shadow_vld[idx_p1] <= 1'b1;
                end else if (shadow_vld[idx_p1] && (shadow[idx_p1] != rdata_p1)) begin
                    err_count <= sat_inc16(err_count);
                end
            end
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^mem.mem_rdata;
    assign err_count    = 16'd0;
`endif

endmodule
